// File: rtl/nabp_filtered_ram_rotate_control_if.sv
// Host / processing / swappable-buffer bundle for the filtered-RAM rotate controller.
// master = the rotate controller, slave = the surrounding host, processing and buffer logic.
interface nabp_filtered_ram_rotate_control_if #(
  parameter int unsigned NUM_BUFS = 3,
  parameter int unsigned ANGLE_W  = 9,
  parameter int unsigned S_W      = 9,
  parameter int unsigned DATA_W   = 16
);
  localparam int unsigned NCH = NUM_BUFS - 1;

  logic [ANGLE_W-1:0]         hs_angle;
  logic                       hs_has_next_angle;
  logic                       hs_next_angle_ack;
  logic                       hs_next_angle;
  logic [S_W-1:0]             hs_s_val;
  logic [NCH*S_W-1:0]         pr_s_val;
  logic                       pr_next_angle;
  logic                       pr_done;
  logic                       pr_next_angle_ack;
  logic [NCH*ANGLE_W-1:0]     pr_angle;
  logic [NCH-1:0]             pr_angle_valid;
  logic [NCH*DATA_W-1:0]      pr_val;
  logic [NUM_BUFS-1:0]        sw_fill_kick;
  logic [NUM_BUFS-1:0]        sw_fill_done;
  logic [NUM_BUFS*S_W-1:0]    sw_hs_s_val;
  logic [NUM_BUFS*S_W-1:0]    sw_pr_s_val;
  logic [NUM_BUFS*DATA_W-1:0] sw_pr_val;

  modport master (
    input  hs_angle, hs_has_next_angle, hs_next_angle_ack,
    input  pr_s_val, pr_next_angle, pr_done,
    input  sw_fill_done, sw_hs_s_val, sw_pr_val,
    output hs_next_angle, hs_s_val,
    output pr_next_angle_ack, pr_angle, pr_angle_valid, pr_val,
    output sw_fill_kick, sw_pr_s_val
  );

  modport slave (
    output hs_angle, hs_has_next_angle, hs_next_angle_ack,
    output pr_s_val, pr_next_angle, pr_done,
    output sw_fill_done, sw_hs_s_val, sw_pr_val,
    input  hs_next_angle, hs_s_val,
    input  pr_next_angle_ack, pr_angle, pr_angle_valid, pr_val,
    input  sw_fill_kick, sw_pr_s_val
  );
endinterface

// File: rtl/nabp_filtered_ram_rotate_control.sv
// Rotates NUM_BUFS filtered-RAM buffers between one host-fill role and NUM_BUFS-1 processing channels.
// Optional macro NABP_ROTATE_STALL_COUNT_EN enables the saturating stall_cnt counter.
module nabp_filtered_ram_rotate_control #(
  parameter int unsigned NUM_BUFS = 3,
  parameter int unsigned ANGLE_W  = 9,
  parameter int unsigned S_W      = 9,
  parameter int unsigned DATA_W   = 16
) (
  input  logic        clk_out,
  input  logic        reset_n,
  nabp_filtered_ram_rotate_control_if.master bus,
  output logic [15:0] stall_cnt
);
  localparam int unsigned NCH   = NUM_BUFS - 1;
  localparam int unsigned SEL_W = $clog2(NUM_BUFS);
  localparam int unsigned CNT_W = $clog2(NUM_BUFS);

  typedef enum logic [2:0] {
    ST_READY, ST_FILL, ST_PRIME, ST_STEADY, ST_DRAIN, ST_WAIT_DONE
  } state_t;

  state_t                         r_state, w_state_nxt;
  logic [SEL_W-1:0]               r_rotate_sel;
  logic [CNT_W-1:0]               r_cnt, w_cnt_nxt;
  logic                           r_fill_kick;
  logic                           r_valid_d;
  logic [NCH-1:0]                 r_pr_angle_valid;
  logic [NCH-1:0][ANGLE_W-1:0]    r_pr_angle;
  logic                           w_rotate;
  logic                           w_hs_next;
  logic                           w_pr_ack;
  logic                           w_fill_done;
  logic [SEL_W-1:0]               w_fill_buf;
  logic [SEL_W-1:0]               w_chan_buf [NCH];

  // Buffer serving a role: (role - rotate_sel) mod NUM_BUFS without a divider.
  function automatic logic [SEL_W-1:0] role_to_buf(input int unsigned role,
                                                   input logic [SEL_W-1:0] sel);
    int unsigned b;
    if (role >= 32'(sel)) b = role - 32'(sel);
    else                  b = role + NUM_BUFS - 32'(sel);
    return SEL_W'(b);
  endfunction

  always_comb begin : role_map
    w_fill_buf = role_to_buf(0, r_rotate_sel);
    for (int unsigned c = 0; c < NCH; c++) w_chan_buf[c] = role_to_buf(c + 1, r_rotate_sel);
  end

  always_comb begin : data_mux
    bus.hs_s_val    = bus.sw_hs_s_val[32'(w_fill_buf)*S_W +: S_W];
    bus.pr_val      = '0;
    bus.sw_pr_s_val = '0;
    for (int unsigned c = 0; c < NCH; c++) begin
      bus.pr_val[c*DATA_W +: DATA_W] = bus.sw_pr_val[32'(w_chan_buf[c])*DATA_W +: DATA_W];
      bus.sw_pr_s_val[32'(w_chan_buf[c])*S_W +: S_W] = bus.pr_s_val[c*S_W +: S_W];
    end
  end

  // The kick cycle masks a stale done from the buffer that was just handed to the host.
  always_comb begin : fill_ctrl
    w_fill_done                  = bus.sw_fill_done[w_fill_buf] & ~r_fill_kick;
    bus.sw_fill_kick             = '0;
    bus.sw_fill_kick[w_fill_buf] = r_fill_kick;
  end

  always_comb begin : fsm_comb
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_rotate    = 1'b0;
    w_hs_next   = 1'b0;
    w_pr_ack    = 1'b0;
    case (r_state)
      ST_READY: begin
        w_hs_next = 1'b1;
        if (bus.hs_next_angle_ack) begin
          w_rotate    = 1'b1;
          w_state_nxt = ST_FILL;
        end
      end
      ST_FILL: begin
        if (w_fill_done) begin
          w_hs_next = 1'b1;
          if (bus.hs_next_angle_ack) begin
            w_rotate    = 1'b1;
            w_pr_ack    = 1'b1;
            w_state_nxt = ST_PRIME;
            w_cnt_nxt   = CNT_W'(1);
          end
        end
      end
      ST_PRIME, ST_STEADY: begin
        if (w_fill_done && bus.pr_next_angle) begin
          w_hs_next = bus.hs_has_next_angle;
          if (bus.hs_next_angle_ack || !bus.hs_has_next_angle) begin
            w_rotate = 1'b1;
            w_pr_ack = 1'b1;
            if (r_state == ST_PRIME) begin
              if (r_cnt == CNT_W'(NUM_BUFS - 2)) w_state_nxt = ST_STEADY;
              else                               w_cnt_nxt   = r_cnt + CNT_W'(1);
            end else if (!bus.hs_has_next_angle) begin
              w_state_nxt = ST_DRAIN;
              w_cnt_nxt   = CNT_W'(1);
            end
          end
        end
      end
      ST_DRAIN: begin
        if (bus.pr_next_angle) begin
          w_rotate = 1'b1;
          w_pr_ack = 1'b1;
          if (r_cnt == CNT_W'(NUM_BUFS - 2)) w_state_nxt = ST_WAIT_DONE;
          else                               w_cnt_nxt   = r_cnt + CNT_W'(1);
        end
      end
      ST_WAIT_DONE: begin
        if (bus.pr_done) w_state_nxt = ST_READY;
      end
      default: w_state_nxt = ST_READY;
    endcase
  end

  assign bus.hs_next_angle     = w_hs_next;
  assign bus.pr_next_angle_ack = w_pr_ack;

  always_ff @(posedge clk_out) begin : ctrl_regs
    if (!reset_n) begin
      r_state          <= ST_READY;
      r_rotate_sel     <= '0;
      r_cnt            <= '0;
      r_fill_kick      <= 1'b0;
      r_valid_d        <= 1'b0;
      r_pr_angle_valid <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_fill_kick <= w_rotate;
      if (w_rotate) begin
        r_rotate_sel     <= (r_rotate_sel == SEL_W'(NUM_BUFS - 1)) ? '0 : r_rotate_sel + SEL_W'(1);
        r_valid_d        <= bus.hs_has_next_angle;
        r_pr_angle_valid <= {r_pr_angle_valid[NCH-2:0], r_valid_d};
      end
    end
  end

  // Angle pipeline carries no reset; its valid bits qualify it.
  always_ff @(posedge clk_out) begin : angle_pipe
    if (w_rotate) r_pr_angle <= {r_pr_angle[NCH-2:0], bus.hs_angle};
  end

  assign bus.pr_angle       = r_pr_angle;
  assign bus.pr_angle_valid = r_pr_angle_valid;

`ifdef NABP_ROTATE_STALL_COUNT_EN
  logic [15:0] r_stall_cnt;

  // Cycles where processing waits on an unfinished fill.
  always_ff @(posedge clk_out) begin : stall_counter
    if (!reset_n) begin
      r_stall_cnt <= '0;
    end else if ((r_state == ST_PRIME || r_state == ST_STEADY) && bus.pr_next_angle &&
                 !w_fill_done && (r_stall_cnt != 16'hFFFF)) begin
      r_stall_cnt <= r_stall_cnt + 16'd1;
    end
  end

  assign stall_cnt = r_stall_cnt;
`else
  assign stall_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_nabp_filtered_ram_rotate_control.sv
// Bench for nabp_filtered_ram_rotate_control: scoreboarded rotate sequence on a 4-buffer
// instance plus directed mapping / stall / reset checks on a 3-buffer instance.
`timescale 1ns/1ps
module tb_nabp_filtered_ram_rotate_control;
  localparam int unsigned ANGLE_W = 9;
  localparam int unsigned S_W     = 9;
  localparam int unsigned DATA_W  = 16;
`ifdef NABP_ROTATE_STALL_COUNT_EN
  localparam logic [15:0] EXP_STALL = 16'd5;
`else
  localparam logic [15:0] EXP_STALL = 16'd0;
`endif

  logic        clk_out = 1'b0;
  logic        rst3_n, rst4_n;
  logic [15:0] stall3, stall4;
  int          checks   = 0;
  int          failures = 0;
  int          n_kicks  = 0;

  always #5 clk_out = ~clk_out;

  nabp_filtered_ram_rotate_control_if #(.NUM_BUFS(3), .ANGLE_W(ANGLE_W), .S_W(S_W), .DATA_W(DATA_W)) b3 ();
  nabp_filtered_ram_rotate_control_if #(.NUM_BUFS(4), .ANGLE_W(ANGLE_W), .S_W(S_W), .DATA_W(DATA_W)) b4 ();

  nabp_filtered_ram_rotate_control #(.NUM_BUFS(3), .ANGLE_W(ANGLE_W), .S_W(S_W), .DATA_W(DATA_W)) dut3 (
    .clk_out(clk_out), .reset_n(rst3_n), .bus(b3), .stall_cnt(stall3));
  nabp_filtered_ram_rotate_control #(.NUM_BUFS(4), .ANGLE_W(ANGLE_W), .S_W(S_W), .DATA_W(DATA_W)) dut4 (
    .clk_out(clk_out), .reset_n(rst4_n), .bus(b4), .stall_cnt(stall4));

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  // Expected picture one cycle after each rotate of the 4-buffer instance.
  typedef struct packed {
    logic [3:0]         kick;
    logic [2:0]         valid;
    logic [ANGLE_W-1:0] a0;
  } exp_t;
  exp_t sb_q[$];

  always @(negedge clk_out) begin : monitor
    exp_t e;
    if (rst4_n === 1'b1 && b4.sw_fill_kick != 4'b0000) begin
      if (sb_q.size() == 0) begin
        check("sb_unexpected_kick", 64'(b4.sw_fill_kick), 64'd0);
      end else begin
        e = sb_q.pop_front();
        check("sb_fill_kick",   64'(b4.sw_fill_kick),               64'(e.kick));
        check("sb_angle_valid", 64'(b4.pr_angle_valid),             64'(e.valid));
        check("sb_angle_ch0",   64'(b4.pr_angle[ANGLE_W-1:0]),      64'(e.a0));
        n_kicks++;
      end
    end
  end

  logic [ANGLE_W-1:0] angles    [6] = '{9'd17, 9'd34, 9'd51, 9'd68, 9'd85, 9'd102};
  logic [3:0]         exp_kick  [9] = '{4'b1000, 4'b0100, 4'b0010, 4'b0001, 4'b1000,
                                        4'b0100, 4'b0010, 4'b0001, 4'b1000};
  logic [2:0]         exp_valid [9] = '{3'd0, 3'd1, 3'd3, 3'd7, 3'd7, 3'd7, 3'd7, 3'd6, 3'd4};
  logic [ANGLE_W-1:0] exp_a0    [9] = '{9'd17, 9'd34, 9'd51, 9'd68, 9'd85, 9'd102, 9'd0, 9'd0, 9'd0};

  initial begin : stimulus
    int  idx;
    int  n_host;
    int  grants;
    logic fire;

    rst3_n = 1'b0;
    rst4_n = 1'b0;
    b3.hs_angle = '0; b3.hs_has_next_angle = 1'b1; b3.hs_next_angle_ack = 1'b0;
    b3.pr_s_val = '0; b3.pr_next_angle = 1'b0;     b3.pr_done = 1'b0;
    b3.sw_fill_done = '0; b3.sw_hs_s_val = '0;     b3.sw_pr_val = '0;
    b4.hs_angle = '0; b4.hs_has_next_angle = 1'b0; b4.hs_next_angle_ack = 1'b0;
    b4.pr_s_val = '0; b4.pr_next_angle = 1'b0;     b4.pr_done = 1'b0;
    b4.sw_fill_done = '1; b4.sw_hs_s_val = '0;     b4.sw_pr_val = '0;

    // ---- 4 buffers: six angles end to end ----
    repeat (2) @(posedge clk_out);
    #1 rst4_n = 1'b1;
    @(negedge clk_out);
    check("r4_hs_next_angle", 64'(b4.hs_next_angle),     64'd1);
    check("r4_pr_ack",        64'(b4.pr_next_angle_ack), 64'd0);
    check("r4_angle_valid",   64'(b4.pr_angle_valid),    64'd0);
    check("r4_fill_kick",     64'(b4.sw_fill_kick),      64'd0);

    for (int k = 0; k < 9; k++) sb_q.push_back('{exp_kick[k], exp_valid[k], exp_a0[k]});
    @(posedge clk_out);
    #1;
    idx = 0; n_host = 0;
    b4.hs_angle = angles[0]; b4.hs_has_next_angle = 1'b1;
    b4.hs_next_angle_ack = 1'b1; b4.pr_next_angle = 1'b1;
    for (int cyc = 0; cyc < 60; cyc++) begin
      @(negedge clk_out);
      fire = b4.hs_next_angle && b4.hs_next_angle_ack;
      @(posedge clk_out);
      #1;
      if (fire) begin
        idx++;
        n_host++;
        if (idx < 6) b4.hs_angle = angles[idx];
        else         b4.hs_angle = '0;
        b4.hs_has_next_angle = (idx < 6);
      end
    end
    @(negedge clk_out);
    check("q4_host_rotates",   64'(n_host),               64'd6);
    check("q4_total_rotates",  64'(n_kicks),              64'd9);
    check("q4_sb_empty",       64'(sb_q.size()),          64'd0);
    check("q4_wait_hs_next",   64'(b4.hs_next_angle),     64'd0);
    check("q4_wait_pr_ack",    64'(b4.pr_next_angle_ack), 64'd0);

    b4.hs_next_angle_ack = 1'b0;
    b4.pr_done = 1'b1;
    @(posedge clk_out);
    #1 b4.pr_done = 1'b0;
    @(negedge clk_out);
    check("q4_done_ready",     64'(b4.hs_next_angle),     64'd1);

    // ---- 3 buffers: kick placement, muxing, stall, reset in DRAIN ----
    @(posedge clk_out);
    #1 rst3_n = 1'b1;
    @(negedge clk_out);
    check("r3_hs_next_angle", 64'(b3.hs_next_angle),     64'd1);
    check("r3_fill_kick",     64'(b3.sw_fill_kick),      64'd0);
    check("r3_angle_valid",   64'(b3.pr_angle_valid),    64'd0);
    check("r3_stall_cnt",     64'(stall3),               64'd0);

    @(posedge clk_out);
    #1 b3.hs_next_angle_ack = 1'b1; b3.hs_angle = 9'd11;
    @(negedge clk_out);
    check("n3_ready_pr_ack",  64'(b3.pr_next_angle_ack), 64'd0);
    @(posedge clk_out);
    #1 b3.hs_next_angle_ack = 1'b0; b3.sw_fill_done = '1; b3.hs_angle = 9'd22;
    @(negedge clk_out);
    check("n3_kick_sel1",       64'(b3.sw_fill_kick),  64'h4);
    check("n3_kick_masks_done", 64'(b3.hs_next_angle), 64'd0);

    @(posedge clk_out);
    #1 b3.hs_next_angle_ack = 1'b1;
    @(negedge clk_out);
    check("n3_fill_hs_next", 64'(b3.hs_next_angle),     64'd1);
    check("n3_fill_pr_ack",  64'(b3.pr_next_angle_ack), 64'd1);
    @(posedge clk_out);
    #1 b3.hs_next_angle_ack = 1'b0; b3.hs_angle = 9'd33;
    b3.sw_hs_s_val = {9'd300, 9'd200, 9'd100};
    b3.sw_pr_val   = {16'hC002, 16'hB001, 16'hA000};
    b3.pr_s_val    = {9'd77, 9'd66};
    @(negedge clk_out);
    check("n3_kick_sel2",     64'(b3.sw_fill_kick),        64'h2);
    check("n3_hs_s_val_sel2", 64'(b3.hs_s_val),            64'd200);
    check("n3_pr_val_sel2",   64'(b3.pr_val),              64'hA000C002);
    check("n3_sw_pr_s_buf0",  64'(b3.sw_pr_s_val[8:0]),    64'd77);
    check("n3_sw_pr_s_buf2",  64'(b3.sw_pr_s_val[26:18]),  64'd66);
    check("n3_prime_idle",    64'(b3.pr_next_angle_ack),   64'd0);

    @(posedge clk_out);
    #1 b3.pr_next_angle = 1'b1; b3.hs_next_angle_ack = 1'b1;
    @(negedge clk_out);
    check("n3_prime_pr_ack",  64'(b3.pr_next_angle_ack), 64'd1);
    @(posedge clk_out);
    #1 b3.pr_next_angle = 1'b0; b3.hs_next_angle_ack = 1'b0;
    @(negedge clk_out);
    check("n3_kick_sel0",     64'(b3.sw_fill_kick),      64'h1);
    check("n3_angle_valid",   64'(b3.pr_angle_valid),    64'h3);
    check("n3_pr_angle",      64'(b3.pr_angle),          64'({9'd22, 9'd33}));

    @(posedge clk_out);
    #1 b3.sw_fill_done = '0; b3.pr_next_angle = 1'b1; b3.hs_next_angle_ack = 1'b1;
    grants = 0;
    repeat (5) begin
      @(negedge clk_out);
      if (b3.pr_next_angle_ack || b3.hs_next_angle) grants++;
      @(posedge clk_out);
    end
    #1 b3.pr_next_angle = 1'b0; b3.hs_next_angle_ack = 1'b0;
    @(negedge clk_out);
    check("n3_stall_no_grant", 64'(grants), 64'd0);
    check("n3_stall_cnt",      64'(stall3), 64'(EXP_STALL));

    @(posedge clk_out);
    #1 b3.sw_fill_done = '1; b3.hs_has_next_angle = 1'b0; b3.pr_next_angle = 1'b1; b3.hs_angle = 9'd44;
    @(negedge clk_out);
    check("n3_last_pr_ack",   64'(b3.pr_next_angle_ack), 64'd1);
    check("n3_last_hs_next",  64'(b3.hs_next_angle),     64'd0);
    @(posedge clk_out);
    #1 b3.pr_next_angle = 1'b0;
    @(negedge clk_out);
    check("n3_drain_kick",    64'(b3.sw_fill_kick),      64'h4);
    check("n3_drain_hs_s",    64'(b3.hs_s_val),          64'd300);
    check("n3_drain_hs_next", 64'(b3.hs_next_angle),     64'd0);
    check("n3_drain_valid",   64'(b3.pr_angle_valid),    64'h3);
    rst3_n = 1'b0;
    @(posedge clk_out);
    #1 rst3_n = 1'b1;
    @(negedge clk_out);
    check("n3_rst_ready",     64'(b3.hs_next_angle),     64'd1);
    check("n3_rst_valid",     64'(b3.pr_angle_valid),    64'd0);
    check("n3_rst_kick",      64'(b3.sw_fill_kick),      64'd0);
    check("n3_rst_hs_s",      64'(b3.hs_s_val),          64'd100);
    check("n3_rst_pr_val",    64'(b3.pr_val),            64'hC002B001);
    check("n3_rst_stall",     64'(stall3),               64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
